// File: rtl/wb_mux_pkg.sv
// Shared types and helpers for the Wishbone user-area slave mux.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

    // Slave index width, never below one bit.
    function automatic int idx_width(input int num_slaves);
        return (clog2(num_slaves) < 1) ? 1 : clog2(num_slaves);
    endfunction

endpackage

// File: rtl/wb_mux_decoder.sv
// Address window decoder: splits an upstream address into hit flag,
// slave index and in-window byte offset.
module wb_mux_decoder
    import wb_mux_pkg::*;
#(
    parameter int          NUM_SLAVES = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          WIN_BITS   = 20,
    parameter int          IDXW       = idx_width(NUM_SLAVES)
) (
    input  logic [31:0]     adr,
    output logic            hit,
    output logic [IDXW-1:0] idx,
    output logic [31:0]     offset
);

    localparam int          UPPER_LSB = WIN_BITS + IDXW;
    localparam logic [31:0] OFF_MASK  = (32'd1 << WIN_BITS) - 32'd1;

    // Compare the region bits against the base and range-check the index.
    always_comb begin
        idx    = adr[WIN_BITS +: IDXW];
        offset = adr & OFF_MASK;
        hit    = ((adr >> UPPER_LSB) == (BASE_ADDR >> UPPER_LSB)) &&
                 ({{(32-IDXW){1'b0}}, idx} < 32'(NUM_SLAVES));
    end

endmodule

// File: rtl/wb_user_slave_mux.sv
// Wishbone-classic slave mux: one upstream slave port fanned out to
// NUM_SLAVES fixed-size windows, with timeout and unmapped error responses.
// Optional macro WB_MUX_ERR_CNT_EN adds err_cnt_o, a saturating error count.
module wb_user_slave_mux
    import wb_mux_pkg::*;
#(
    parameter int          NUM_SLAVES     = 2,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          WIN_BITS       = 20,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [3:0]               s_sel_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    output logic                     timeout_o
`ifdef WB_MUX_ERR_CNT_EN
    ,
    output logic [15:0]              err_cnt_o
`endif
);

    localparam int          IDXW      = idx_width(NUM_SLAVES);
    localparam logic [15:0] TIMER_END = 16'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [IDXW-1:0]       sel_idx;
    logic [15:0]           timer;
    logic [31:0]           rdata;
    logic [NUM_SLAVES-1:0] strobe;

    logic                  hit;
    logic [IDXW-1:0]       dec_idx;
    logic [31:0]           dec_off;
    logic                  ack_sel;
    logic [31:0]           dat_sel;
    logic [NUM_SLAVES-1:0] req_mask;

    wb_mux_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .WIN_BITS   (WIN_BITS),
        .IDXW       (IDXW)
    ) u_decoder (
        .adr    (wbs_adr_i),
        .hit    (hit),
        .idx    (dec_idx),
        .offset (dec_off)
    );

    assign s_cyc_o = strobe;
    assign s_stb_o = strobe;

    // Select the active slave's ack/data and build the one-hot strobe for a new hit.
    always_comb begin
        ack_sel  = 1'b0;
        dat_sel  = '0;
        req_mask = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (IDXW'(k) == sel_idx) begin
                ack_sel = s_ack_i[k];
                dat_sel = s_dat_i[32*k +: 32];
            end
            req_mask[k] = (IDXW'(k) == dec_idx);
        end
    end

    // Request/response sequencer with registered upstream and downstream outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            sel_idx   <= '0;
            timer     <= '0;
            rdata     <= '0;
            strobe    <= '0;
            s_we_o    <= 1'b0;
            s_sel_o   <= '0;
            s_adr_o   <= '0;
            s_dat_o   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            timeout_o <= 1'b0;
`ifdef WB_MUX_ERR_CNT_EN
            err_cnt_o <= '0;
`endif
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    // The cycle presenting an ack still sees the old strobe high.
                    if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
                        s_we_o  <= wbs_we_i;
                        s_sel_o <= wbs_sel_i;
                        s_adr_o <= dec_off;
                        s_dat_o <= wbs_dat_i;
                        sel_idx <= dec_idx;
                        timer   <= '0;
                        if (hit) begin
                            strobe <= req_mask;
                            state  <= REQ;
                        end else begin
                            rdata <= wbs_we_i ? 32'd0 : ERR_DATA;
                            state <= RESP;
`ifdef WB_MUX_ERR_CNT_EN
                            if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
`endif
                        end
                    end
                end
                REQ: begin
                    if (!wbs_cyc_i) begin
                        strobe <= '0;
                        state  <= IDLE;
                    end else if (ack_sel) begin
                        rdata  <= s_we_o ? 32'd0 : dat_sel;
                        strobe <= '0;
                        state  <= RESP;
                    end else if (timer == TIMER_END) begin
                        rdata     <= s_we_o ? 32'd0 : ERR_DATA;
                        strobe    <= '0;
                        timeout_o <= 1'b1;
                        state     <= RESP;
`ifdef WB_MUX_ERR_CNT_EN
                        if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
`endif
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= rdata;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
